// File: rtl/i2s_tx_serializer_pkg.sv
// Shared encodings and the sample alignment helper for the I2S transmit serializer.
package i2s_tx_serializer_pkg;

    localparam int SLOT_BITS = 32;

    typedef enum logic [1:0] {
        WLEN_8  = 2'b00,
        WLEN_16 = 2'b01,
        WLEN_24 = 2'b10,
        WLEN_32 = 2'b11
    } wlen_e;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Keep the wlen valid LSBs of a word, left-aligned in the slot with zero pad below.
    function automatic logic [SLOT_BITS-1:0] align_sample(input logic [SLOT_BITS-1:0] word,
                                                          input wlen_e wlen);
        logic [SLOT_BITS-1:0] res;
        case (wlen)
            WLEN_8:  res = {word[7:0], 24'h000000};
            WLEN_16: res = {word[15:0], 16'h0000};
            WLEN_24: res = {word[23:0], 8'h00};
            WLEN_32: res = word;
            default: res = {SLOT_BITS{1'b0}};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_sck_gen.sv
// SCK divider: half period of div_i+1 clocks, with a falling-edge strobe for the frame engine.
module i2s_tx_serializer_sck_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 sck_o,
    output logic                 fall_tick_o
);

    logic [DIV_WIDTH-1:0] cnt_r;
    logic                 sck_r;
    logic                 first_r;
    logic                 wrap_s;

    // The first wrap after a clear is a virtual falling edge: SCK stays low.
    always_comb begin
        wrap_s      = 1'b0;
        fall_tick_o = 1'b0;
        if (clr_i) begin
            wrap_s      = 1'b0;
            fall_tick_o = 1'b0;
        end else begin
            wrap_s      = (cnt_r == div_i);
            fall_tick_o = wrap_s & (sck_r | first_r);
        end
    end

    // Divider counter and SCK toggle register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r   <= {DIV_WIDTH{1'b0}};
            sck_r   <= 1'b0;
            first_r <= 1'b1;
        end else if (clr_i) begin
            cnt_r   <= {DIV_WIDTH{1'b0}};
            sck_r   <= 1'b0;
            first_r <= 1'b1;
        end else if (wrap_s) begin
            cnt_r   <= {DIV_WIDTH{1'b0}};
            sck_r   <= first_r ? 1'b0 : ~sck_r;
            first_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign sck_o = sck_r;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Master-mode I2S transmit back end: pops PCM words, generates SCK/WS and shifts data MSB first.
module i2s_tx_serializer
    import i2s_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic [1:0]            wlen_i,
    input  logic                  fmt_i,
    input  logic                  pol_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  sck_o,
    output logic                  ws_o,
    output logic                  sd_o,
    output logic                  busy_o,
    output logic                  underflow_o,
    output logic                  frame_o
);

    state_e                state_r;
    logic                  cfg_seen_r;
    logic [DIV_WIDTH-1:0]  div_q_r;
    wlen_e                 wlen_q_r;
    fmt_e                  fmt_q_r;
    logic                  pol_q_r;
    logic [5:0]            b_r;
    logic                  started_r;
    logic [SLOT_BITS-1:0]  sreg_r;
    logic                  ws_raw_r;
    logic                  tx_ready_r;
    logic                  underflow_r;
    logic                  frame_r;

    logic                  run_s;
    logic                  fall_tick_s;
    logic [5:0]            b_next_s;
    logic [4:0]            load_bit_s;
    logic                  load_s;
    logic [SLOT_BITS-1:0]  load_word_s;
    logic                  pol_s;

    assign run_s = en_i & (state_r == ST_RUN);

    i2s_tx_serializer_sck_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sck_gen (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (~run_s),
        .div_i       (div_q_r),
        .sck_o       (sck_o),
        .fall_tick_o (fall_tick_s)
    );

    // Next bit index, load point and the word to load; WS idles at pol_i until a config is latched.
    always_comb begin
        b_next_s    = 6'd0;
        load_bit_s  = 5'd1;
        load_word_s = {SLOT_BITS{1'b0}};
        pol_s       = 1'b0;
        if (started_r) begin
            b_next_s = b_r + 6'd1;
        end else begin
            b_next_s = 6'd0;
        end
        if (fmt_q_r == FMT_LJ) begin
            load_bit_s = 5'd0;
        end else begin
            load_bit_s = 5'd1;
        end
        if (tx_valid_i) begin
            load_word_s = align_sample(tx_data_i[SLOT_BITS-1:0], wlen_q_r);
        end else begin
            load_word_s = {SLOT_BITS{1'b0}};
        end
        if (cfg_seen_r) begin
            pol_s = pol_q_r;
        end else begin
            pol_s = pol_i;
        end
    end

    assign load_s = fall_tick_s & (b_next_s[4:0] == load_bit_s);

    // Word is captured at the load edge; the pop strobe follows while it is still at the FIFO head.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            cfg_seen_r  <= 1'b0;
            div_q_r     <= {DIV_WIDTH{1'b0}};
            wlen_q_r    <= WLEN_8;
            fmt_q_r     <= FMT_I2S;
            pol_q_r     <= 1'b0;
            b_r         <= 6'd0;
            started_r   <= 1'b0;
            sreg_r      <= {SLOT_BITS{1'b0}};
            ws_raw_r    <= 1'b0;
            tx_ready_r  <= 1'b0;
            underflow_r <= 1'b0;
            frame_r     <= 1'b0;
        end else begin
            tx_ready_r  <= 1'b0;
            underflow_r <= 1'b0;
            frame_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    b_r       <= 6'd0;
                    started_r <= 1'b0;
                    sreg_r    <= {SLOT_BITS{1'b0}};
                    ws_raw_r  <= 1'b0;
                    if (en_i) begin
                        div_q_r    <= div_i;
                        wlen_q_r   <= wlen_e'(wlen_i);
                        fmt_q_r    <= fmt_e'(fmt_i);
                        pol_q_r    <= pol_i;
                        cfg_seen_r <= 1'b1;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        state_r   <= ST_IDLE;
                        b_r       <= 6'd0;
                        started_r <= 1'b0;
                        sreg_r    <= {SLOT_BITS{1'b0}};
                        ws_raw_r  <= 1'b0;
                    end else if (fall_tick_s) begin
                        b_r       <= b_next_s;
                        started_r <= 1'b1;
                        ws_raw_r  <= b_next_s[5];
                        frame_r   <= (b_next_s == 6'd0);
                        if (load_s) begin
                            sreg_r      <= load_word_s;
                            tx_ready_r  <= tx_valid_i;
                            underflow_r <= ~tx_valid_i;
                        end else begin
                            sreg_r <= {sreg_r[SLOT_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o  = tx_ready_r;
    assign underflow_o = underflow_r;
    assign frame_o     = frame_r;
    assign sd_o        = sreg_r[SLOT_BITS-1];
    assign ws_o        = ws_raw_r ^ pol_s;
    assign busy_o      = (state_r == ST_RUN);

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomized bench: per-cycle outputs compared with a timing/arithmetic model of the I2S frame.
module tb_i2s_tx_serializer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic [7:0]  div_i;
    logic [1:0]  wlen_i;
    logic        fmt_i;
    logic        pol_i;
    logic [31:0] tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        sck_o;
    logic        ws_o;
    logic        sd_o;
    logic        busy_o;
    logic        underflow_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: half period, load bit, word length code, polarity, word table.
    int          m_h;
    int          m_d;
    int          m_wlen;
    logic        m_pol;
    logic        m_cfg_seen;
    logic [31:0] words [16];
    bit          avail [16];

    i2s_tx_serializer #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .div_i       (div_i),
        .wlen_i      (wlen_i),
        .fmt_i       (fmt_i),
        .pol_i       (pol_i),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .sck_o       (sck_o),
        .ws_o        (ws_o),
        .sd_o        (sd_o),
        .busy_o      (busy_o),
        .underflow_o (underflow_o),
        .frame_o     (frame_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs[6:0], exp[6:0]);
        end
    endtask

    function automatic logic [6:0] obs_vec();
        return {busy_o, sck_o, ws_o, sd_o, tx_ready_o, underflow_o, frame_o};
    endfunction

    function automatic logic [6:0] idle_vec();
        logic p;
        p = m_cfg_seen ? m_pol : pol_i;
        return {1'b0, 1'b0, p, 4'b0000};
    endfunction

    // Slot content for load w: wlen valid LSBs, MSB first, zero padded; zeros on underflow.
    function automatic logic [31:0] exp_slot_word(input int w);
        longint unsigned nbits;
        longint unsigned v;
        if (!avail[w]) return 32'h0;
        nbits = 64'(8 * (m_wlen + 1));
        v = 64'(words[w]) % (64'd1 << nbits);
        return 32'(v << (64'd32 - nbits));
    endfunction

    // Expected outputs n clocks after the enabling edge.
    function automatic logic [6:0] model_out(input int n);
        int m, k, b, p, w, ph;
        logic s, ws, sd, rd, uf, fr;
        logic [31:0] a;
        if (n < m_h) return {1'b1, 1'b0, m_pol, 4'b0000};
        m  = n - m_h;
        ph = m % (2 * m_h);
        k  = m / (2 * m_h);
        b  = k % 64;
        s  = (ph >= m_h);
        ws = (b >= 32) ^ m_pol;
        fr = (ph == 0) && (b == 0);
        sd = 1'b0;
        rd = 1'b0;
        uf = 1'b0;
        if (k >= m_d) begin
            p = k - m_d;
            w = p / 32;
            if (w > 15) w = 15;
            a  = exp_slot_word(w);
            sd = a[31 - (p % 32)];
            if ((ph == 0) && (p % 32 == 0)) begin
                rd = avail[w];
                uf = !avail[w];
            end
        end
        return {1'b1, s, ws, sd, rd, uf, fr};
    endfunction

    // Index of the word the FIFO should present for the next edge.
    function automatic int next_idx(input int n);
        int n0;
        n0 = m_h + 2 * m_h * m_d;
        if (n < n0) return 0;
        return ((n - m_h) / (2 * m_h) - m_d) / 32 + 1;
    endfunction

    task automatic drive_fifo(input int idx);
        int i;
        i = (idx > 15) ? 15 : idx;
        tx_valid_i = avail[i];
        tx_data_i  = avail[i] ? words[i] : $urandom();
    endtask

    task automatic set_words();
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom();
            avail[i] = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic start_run(input int div, input int wlen, input int fmt, input logic pol);
        div_i      = 8'(div);
        wlen_i     = 2'(wlen);
        fmt_i      = 1'(fmt);
        pol_i      = pol;
        en_i       = 1'b1;
        m_h        = div + 1;
        m_d        = (fmt != 0) ? 0 : 1;
        m_wlen     = wlen;
        m_pol      = pol;
        m_cfg_seen = 1'b1;
        drive_fifo(0);
    endtask

    // Check every cycle; config inputs are scrambled to prove they are ignored while busy.
    task automatic run_cycles(input string name, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check_eq($sformatf("%s n=%0d", name, n), 32'(obs_vec()), 32'(model_out(n)));
            drive_fifo(next_idx(n));
            div_i  = 8'($urandom());
            wlen_i = 2'($urandom());
            fmt_i  = 1'($urandom());
            pol_i  = 1'($urandom());
        end
    endtask

    task automatic idle_cycles(input string name, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check_eq($sformatf("%s idle=%0d", name, n), 32'(obs_vec()), 32'(idle_vec()));
        end
    endtask

    initial begin
        rst_n_i    = 1'b1;
        en_i       = 1'b0;
        div_i      = 8'd0;
        wlen_i     = 2'b00;
        fmt_i      = 1'b0;
        pol_i      = 1'b1;
        tx_data_i  = 32'h0;
        tx_valid_i = 1'b0;
        m_cfg_seen = 1'b0;
        m_pol      = 1'b0;
        m_h        = 1;
        m_d        = 1;
        m_wlen     = 0;
        #1 rst_n_i = 1'b0;
        #1 check_eq("reset pol1", 32'(obs_vec()), 32'(idle_vec()));
        pol_i = 1'b0;
        #1 check_eq("reset pol0", 32'(obs_vec()), 32'(idle_vec()));
        pol_i = 1'b1;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle_cycles("post_reset", 3);

        // Philips, 16-bit, div=1
        set_words();
        words[0] = 32'h0000_A5F0; avail[0] = 1'b1;
        words[1] = 32'h0000_0F5A; avail[1] = 1'b1;
        start_run(1, 1, 0, 1'b0);
        run_cycles("i2s16", 2 * 128 * 2 + 20);
        en_i = 1'b0;
        idle_cycles("i2s16", 2);

        // Left-justified, 32-bit
        set_words();
        words[0] = 32'h8000_0001; avail[0] = 1'b1;
        avail[1] = 1'b1;
        start_run(1, 3, 1, 1'b0);
        run_cycles("lj32", 2 * 128 * 2 + 10);
        en_i = 1'b0;
        idle_cycles("lj32", 3);

        // Empty FIFO for one right slot, div=0
        set_words();
        avail[0] = 1'b1; avail[1] = 1'b0; avail[2] = 1'b1; avail[3] = 1'b1;
        start_run(0, 1, 0, 1'b0);
        run_cycles("underflow", 3 * 128 + 10);
        en_i = 1'b0;
        idle_cycles("underflow", 1);

        // Abort at b=20 with a single low cycle, restart at div=3
        set_words();
        start_run(2, 2, 0, 1'b1);
        run_cycles("abort_pre", 3 + 2 * 3 * 20 + 1);
        en_i = 1'b0;
        idle_cycles("abort", 1);
        set_words();
        start_run(3, 1, 0, 1'b0);
        run_cycles("abort_post", 128 * 4 + 20);
        en_i = 1'b0;
        idle_cycles("abort_post", 2);

        // Inverted WS, 24-bit with garbage top byte
        set_words();
        words[0] = 32'hFF12_3456; avail[0] = 1'b1;
        words[1] = 32'hA5AB_CDEF; avail[1] = 1'b1;
        start_run(0, 2, 0, 1'b1);
        run_cycles("pol24", 2 * 128 + 10);
        en_i = 1'b0;
        idle_cycles("pol24", 2);

        // Asynchronous reset in the middle of a slot
        set_words();
        start_run(1, 1, 0, 1'b0);
        run_cycles("rst_pre", 150);
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        pol_i      = 1'b1;
        m_cfg_seen = 1'b0;
        #1 check_eq("async_reset", 32'(obs_vec()), 32'(idle_vec()));
        @(negedge clk_i);
        check_eq("reset_hold", 32'(obs_vec()), 32'(idle_vec()));
        rst_n_i = 1'b1;
        set_words();
        start_run(1, 3, 0, 1'b0);
        run_cycles("rst_post", 2 * 128 * 2);
        en_i = 1'b0;
        idle_cycles("rst_post", 2);

        // Random configurations
        for (int r = 0; r < 6; r++) begin
            set_words();
            start_run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                      1'($urandom_range(0, 1)));
            run_cycles($sformatf("rand%0d", r), 2 * 128 * m_h + $urandom_range(0, 60));
            en_i = 1'b0;
            idle_cycles($sformatf("rand%0d", r), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
